rv_fetch_stage: RTL and testbench

// - IF stage of the RV32I pipeline. Owns the PC and issues word fetches on a valid/ready imem request port.
// - Accepts in-order imem responses of any latency >=1 and buffers them in a reservation queue.
// - Presents {pc, pc+4, instr} to ID with a valid/ready handshake.
// - Handles branch/jump redirects from EX, discarding wrong-path in-flight responses.

---
 rtl/rv_fetch_stage_pkg.sv | 24 ++
 rtl/rv_fetch_queue.sv | 78 +++++++
 rtl/rv_fetch_stage.sv | 109 ++++++++++
 tb/tb_rv_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_stage_pkg
// Description : Shared widths, constants and the fetch queue entry type for
//               the RV32I instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_fetch_stage_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] INSTR_NOP        = 32'h0000_0013;

  // One reservation slot: the fetch address and, once returned, its word.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  filled;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_queue
// Description : Circular reservation queue of fetch entries. Entries are
//               allocated at issue time, filled in order as responses return
//               and popped from the head when ID accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_queue
  import rv_fetch_stage_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc,
  input  logic [ADDR_WIDTH-1:0] alloc_pc,
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output fetch_entry_t          head
);

  localparam int PW = $clog2(QDEPTH);

  fetch_entry_t          entries [QDEPTH];
  logic [PW-1:0]         head_ptr;
  logic [PW-1:0]         tail_ptr;
  logic [PW-1:0]         fill_ptr;

  // Pointer/count bookkeeping and entry storage; flush drops every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        entries[i].pc     <= '0;
        entries[i].instr  <= INSTR_NOP;
        entries[i].filled <= 1'b0;
      end
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      // A full queue may pop and allocate the same slot; alloc wins the pc.
      if (pop) begin
        entries[head_ptr].filled <= 1'b0;
        head_ptr                 <= head_ptr + PW'(1);
      end
      if (alloc) begin
        entries[tail_ptr].pc     <= alloc_pc;
        entries[tail_ptr].filled <= 1'b0;
        tail_ptr                 <= tail_ptr + PW'(1);
      end
      // The fill pointer always names the oldest allocated, unfilled slot.
      if (fill) begin
        entries[fill_ptr].instr  <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + PW'(1);
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  assign head = entries[head_ptr];

endmodule
`default_nettype wire

// File: rtl/rv_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch_stage
// Description : RV32I IF stage. Owns the PC, issues word fetches to imem,
//               buffers in-order responses and hands {pc, pc+4, instr} to ID.
//               EX redirects flush the queue and discard wrong-path returns.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch_stage
  import rv_fetch_stage_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                    QDEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_req_ready_i,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [ADDR_WIDTH-1:0] id_pc4_o,
  output logic [DATA_WIDTH-1:0] id_instr_o
);

  localparam int            CW       = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         q_count;
  fetch_entry_t          head;
  logic                  pop;
  logic                  issue;
  logic                  rsp_take;
  logic                  rsp_fill;

  // Handshake decode. Issue is held off during reset so the first request
  // appears only once rst_n is released. The outstanding term only binds
  // after a redirect, when dropped responses have no queue slot of their own.
  always_comb begin
    id_valid_o       = head.filled && !redirect_i;
    pop              = id_valid_o && id_ready_i;
    imem_req_valid_o = rst_n && !redirect_i
                       && ((q_count < QDEPTH_C) || pop)
                       && ((outstanding < QDEPTH_C) || imem_rsp_valid_i);
    issue            = imem_req_valid_o && imem_req_ready_i;
    rsp_take         = imem_rsp_valid_i && (outstanding != '0);
    rsp_fill         = rsp_take && (drop_cnt == '0) && !redirect_i;
  end

  assign imem_req_addr_o = pc;
  assign id_pc_o         = head.pc;
  assign id_pc4_o        = head.filled ? head.pc + ADDR_WIDTH'(4) : '0;
  assign id_instr_o      = head.instr;

  // PC and in-flight accounting; a redirect re-targets the PC and marks every
  // still-unanswered request as wrong-path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_i) begin
      pc          <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      outstanding <= outstanding - CW'(rsp_take);
      drop_cnt    <= outstanding - CW'(rsp_take);
    end else begin
      if (issue) begin
        pc <= pc + ADDR_WIDTH'(4);
      end
      outstanding <= outstanding + CW'(issue) - CW'(rsp_take);
      if (rsp_take && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  rv_fetch_queue #(
    .QDEPTH    (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (issue),
    .alloc_pc  (pc),
    .fill      (rsp_fill),
    .fill_data (imem_rsp_data_i),
    .pop       (pop),
    .flush     (redirect_i),
    .count     (q_count),
    .head      (head)
  );

  // imem must never answer when nothing is in flight.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid_i |-> (outstanding != '0));

  // In-flight counters stay within the queue depth.
  a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= QDEPTH_C) && (drop_cnt <= outstanding));

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_fetch_stage
// Description : Self-checking bench for rv_fetch_stage: cycle table plus
//               imem model and in-order scoreboard, with redirect and reset
//               corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch_stage;
  import rv_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect, id_valid, id_ready;
  logic [31:0] redirect_pc, id_pc, id_pc4, id_instr;

  always #5 clk = ~clk;

  rv_fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_addr_o  (imem_req_addr),
    .imem_req_ready_i (imem_req_ready),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_pc_o          (id_pc),
    .id_pc4_o         (id_pc4),
    .id_instr_o       (id_instr)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;

  // Stimulus for the next cycle.
  logic        s_rst_n = 1'b0, s_req_ready = 1'b1, s_id_ready = 1'b1, s_redir = 1'b0;
  logic [31:0] s_redir_pc = 32'h0;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t        rspq[$];
  logic [31:0] expq[$];
  int          pops = 0;
  logic [31:0] last_pop_pc, last_pop_pc4;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_instr;

  typedef struct {
    logic rst_n; logic req_ready; logic id_ready;
    logic exp_req_valid; logic [31:0] exp_addr; logic exp_id_valid; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rr, input logic ir,
                     input logic ev, input logic [31:0] ea, input logic iv, input logic [31:0] ip);
    vec_t v;
    v.rst_n = r; v.req_ready = rr; v.id_ready = ir;
    v.exp_req_valid = ev; v.exp_addr = ea; v.exp_id_valid = iv; v.exp_pc = ip;
    tbl.push_back(v);
  endtask

  // Scoreboard and imem bookkeeping for the handshakes committed at the next edge.
  task automatic observe();
    logic [31:0] e;
    rsp_t        r;
    if (!rst_n) begin
      rspq.delete(); expq.delete(); prev_stall = 1'b0;
      return;
    end
    if (prev_stall && !redirect)
      check("id_hold", {id_valid, id_pc, id_instr}, {1'b1, prev_pc, prev_instr});
    if (imem_req_valid)
      check("addr_align", {30'h0, imem_req_addr[1:0]}, 32'h0);
    if (id_valid && id_ready) begin
      if (expq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_unexpected: got pc %h expected no instruction", id_pc);
      end else begin
        e = expq.pop_front();
        check("sb_pop", {id_pc, id_pc4, id_instr}, {e, e + 32'd4, mem_word(e)});
      end
      pops++; last_pop_pc = id_pc; last_pop_pc4 = id_pc4;
    end
    if (imem_rsp_valid && rspq.size() > 0) r = rspq.pop_front();
    if (redirect) expq.delete();
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr; r.due = cyc + lat;
      rspq.push_back(r);
      expq.push_back(imem_req_addr);
    end
    prev_stall = id_valid && !id_ready;
    prev_pc    = id_pc;
    prev_instr = id_instr;
  endtask

  // One clock: drive just after the edge, evaluate mid-cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    rst_n          = s_rst_n;
    imem_req_ready = s_req_ready;
    id_ready       = s_id_ready;
    redirect       = s_redir;
    redirect_pc    = s_redir_pc;
    if (!s_rst_n) rspq.delete();
    if (rspq.size() > 0 && rspq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(rspq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset(input int l);
    lat = l; s_rst_n = 1'b0; s_redir = 1'b0; s_req_ready = 1'b1; s_id_ready = 1'b1;
    cycle(); cycle();
    s_rst_n = 1'b1;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    int p0;
    int n;
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < 40) begin cycle(); n++; end
    if (pops == p0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: no instruction reached ID within 40 cycles, expected pc %h", name, exp_pc);
    end else begin
      check(name, {last_pop_pc, last_pop_pc4}, {exp_pc, exp_pc + 32'd4});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

    // Reset, streaming with a 6-cycle ID stall at pc 0x8.
    add(0,1,1, 0,32'h00,0,32'h00); add(0,1,1, 0,32'h00,0,32'h00);
    add(1,1,1, 1,32'h00,0,32'h00); add(1,1,1, 1,32'h04,0,32'h00);
    add(1,1,1, 1,32'h08,1,32'h00); add(1,1,1, 1,32'h0C,1,32'h04);
    add(1,1,0, 1,32'h10,1,32'h08); add(1,1,0, 1,32'h14,1,32'h08);
    for (int k = 0; k < 4; k++) add(1,1,0, 0,32'h18,1,32'h08);
    add(1,1,1, 1,32'h18,1,32'h08); add(1,1,1, 1,32'h1C,1,32'h0C);
    add(1,1,1, 1,32'h20,1,32'h10); add(1,1,1, 1,32'h24,1,32'h14);
    add(1,1,1, 1,32'h28,1,32'h18); add(1,1,1, 1,32'h2C,1,32'h1C);
    // Reset, then imem back-pressure for 3 cycles on address 0x10.
    add(0,1,1, 0,32'h00,0,32'h00); add(0,1,1, 0,32'h00,0,32'h00);
    add(1,1,1, 1,32'h00,0,32'h00); add(1,1,1, 1,32'h04,0,32'h00);
    add(1,1,1, 1,32'h08,1,32'h00); add(1,1,1, 1,32'h0C,1,32'h04);
    add(1,0,1, 1,32'h10,1,32'h08); add(1,0,1, 1,32'h10,1,32'h0C);
    add(1,0,1, 1,32'h10,0,32'h00); add(1,1,1, 1,32'h10,0,32'h00);
    add(1,1,1, 1,32'h14,0,32'h00); add(1,1,1, 1,32'h18,1,32'h10);
    add(1,1,1, 1,32'h1C,1,32'h14);

    lat = 1;
    foreach (tbl[i]) begin
      s_rst_n = tbl[i].rst_n; s_req_ready = tbl[i].req_ready;
      s_id_ready = tbl[i].id_ready; s_redir = 1'b0;
      cycle();
      if (!tbl[i].rst_n)
        check($sformatf("vec%0d_reset", i),
              {imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc4, id_instr},
              {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, INSTR_NOP});
      else if (tbl[i].exp_id_valid)
        check($sformatf("vec%0d", i),
              {imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc4, id_instr},
              {tbl[i].exp_req_valid, tbl[i].exp_addr, 1'b1, tbl[i].exp_pc,
               tbl[i].exp_pc + 32'd4, mem_word(tbl[i].exp_pc)});
      else
        check($sformatf("vec%0d", i), {imem_req_valid, imem_req_addr, id_valid},
              {tbl[i].exp_req_valid, tbl[i].exp_addr, 1'b0});
    end

    // Redirect to 0x200 with two 3-cycle responses still in flight.
    do_reset(3);
    cycle(); cycle();
    s_req_ready = 1'b0; s_redir = 1'b1; s_redir_pc = 32'h200;
    cycle();
    check("redir_quiet", {imem_req_valid, id_valid}, 2'b00);
    s_req_ready = 1'b1; s_redir = 1'b0;
    cycle();
    check("redir_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
    wait_pop("redir_first", 32'h200);

    // Redirect coinciding with a response, unaligned target.
    do_reset(1);
    for (int k = 0; k < 6; k++) cycle();
    s_redir = 1'b1; s_redir_pc = 32'h103;
    cycle();
    check("redir_rsp_same", {imem_rsp_valid, id_valid, imem_req_valid}, 3'b100);
    s_redir = 1'b0;
    cycle();
    check("redir_align", {imem_req_valid, imem_req_addr}, {1'b1, 32'h100});
    wait_pop("redir_align_first", 32'h100);

    // Back-to-back redirects: the last target wins.
    for (int k = 0; k < 3; k++) cycle();
    s_redir = 1'b1; s_redir_pc = 32'h300;
    cycle();
    s_redir_pc = 32'h404;
    cycle();
    s_redir = 1'b0;
    cycle();
    check("redir_last_wins", {imem_req_valid, imem_req_addr}, {1'b1, 32'h404});
    wait_pop("redir_last_first", 32'h404);

    // Reset asserted mid-stream with two responses in flight.
    do_reset(2);
    for (int k = 0; k < 6; k++) cycle();
    s_rst_n = 1'b0;
    cycle();
    check("rst_async", {imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc4, id_instr},
          {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, INSTR_NOP});
    cycle();
    s_rst_n = 1'b1;
    cycle();
    check("rst_restart", {imem_req_valid, imem_req_addr, id_valid}, {1'b1, 32'h0, 1'b0});
    wait_pop("rst_first", 32'h0);
    for (int k = 0; k < 6; k++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
